// File: rtl/pkt_tx_framer.sv
// Packet transmit framer.
// Pulls one length-prefixed packet from a packet FIFO and streams it downstream as:
//   PREAMBLE_LEN x 8'hAA, SYNC_BYTE, length, payload[0..len-1] (, CRC hi, CRC lo).
// Optional feature macro: PKT_TX_FRAMER_CRC16_EN.
//   Defined: append CRC-16/CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR)
//   over the payload, high byte first.
//   Undefined: no CRC states or logic, and the frame ends on the last payload byte.
//
// state    | meaning
// IDLE     | waiting for pkt_ready
// GET_LEN  | length strobe issued, wait one cycle, then capture and range-check the length
// PREAMBLE | sending 8'hAA bytes
// SYNC     | sending SYNC_BYTE
// LEN_OUT  | sending the length byte
// FETCH    | rd_en issued, wait one cycle, then capture data_out
// PAYLOAD  | sending the fetched payload byte
// CRC_HI   | sending CRC[15:8] (CRC build only)
// CRC_LO   | sending CRC[7:0] (CRC build only)
// FINISH   | done pulse, then back to IDLE
module pkt_tx_framer #(
   parameter int          PREAMBLE_LEN = 2,
   parameter logic [7:0]  SYNC_BYTE    = 8'hD3,
   parameter int          MAX_LEN      = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pkt_ready,
   input  logic [7:0] length_out,
   output logic       length_rd_en,
   input  logic [7:0] data_out,
   output logic       rd_en,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy,
   output logic       done,
   output logic       len_err
);

   localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);
   localparam logic [1:0] PRE_LAST  = 2'(PREAMBLE_LEN - 1);
   localparam logic [7:0] PRE_BYTE  = 8'hAA;

   typedef enum logic [3:0] {
      IDLE,
      GET_LEN,
      PREAMBLE,
      SYNC,
      LEN_OUT,
      FETCH,
      PAYLOAD,
`ifdef PKT_TX_FRAMER_CRC16_EN
      CRC_HI,
      CRC_LO,
`endif
      FINISH
   } state_t;

   state_t     state;
   logic [7:0] len_q;
   logic [7:0] cnt;
   logic [1:0] pre_cnt;
   logic       wait_q;

`ifdef PKT_TX_FRAMER_CRC16_EN
   logic [15:0] crc_q;

   function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [7:0] byte_in);
      logic [15:0] r;
      r = crc_in ^ {byte_in, 8'h00};
      for (int i = 0; i < 8; i++) begin
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      end
      return r;
   endfunction
`endif

   // Frame sequencer: all outputs are registered here; strobes default low each cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         len_q        <= 8'h00;
         cnt          <= 8'h00;
         pre_cnt      <= 2'd0;
         wait_q       <= 1'b0;
         length_rd_en <= 1'b0;
         rd_en        <= 1'b0;
         out_data     <= 8'h00;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         len_err      <= 1'b0;
`ifdef PKT_TX_FRAMER_CRC16_EN
         crc_q        <= 16'hFFFF;
`endif
      end else begin
         length_rd_en <= 1'b0;
         rd_en        <= 1'b0;
         done         <= 1'b0;
         len_err      <= 1'b0;
         case (state)
            IDLE: begin
               if (pkt_ready) begin
                  length_rd_en <= 1'b1;
                  wait_q       <= 1'b1;
                  busy         <= 1'b1;
                  state        <= GET_LEN;
               end
            end
            GET_LEN: begin
               if (wait_q) begin
                  wait_q <= 1'b0;
               end else if ({1'b0, length_out} > MAX_LEN_W) begin
                  len_err <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  len_q     <= length_out;
                  pre_cnt   <= PRE_LAST;
                  out_data  <= PRE_BYTE;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
`ifdef PKT_TX_FRAMER_CRC16_EN
                  crc_q     <= 16'hFFFF;
`endif
                  state     <= PREAMBLE;
               end
            end
            PREAMBLE: begin
               if (out_ready) begin
                  if (pre_cnt == 2'd0) begin
                     out_data <= SYNC_BYTE;
                     state    <= SYNC;
                  end else begin
                     pre_cnt <= pre_cnt - 2'd1;
                  end
               end
            end
            SYNC: begin
               if (out_ready) begin
                  out_data <= len_q;
`ifdef PKT_TX_FRAMER_CRC16_EN
                  out_last <= 1'b0;
`else
                  out_last <= (len_q == 8'h00);
`endif
                  state    <= LEN_OUT;
               end
            end
            LEN_OUT: begin
               if (out_ready) begin
                  if (len_q == 8'h00) begin
`ifdef PKT_TX_FRAMER_CRC16_EN
                     out_data  <= crc_q[15:8];
                     state     <= CRC_HI;
`else
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     state     <= FINISH;
`endif
                  end else begin
                     out_valid <= 1'b0;
                     cnt       <= len_q;
                     rd_en     <= 1'b1;
                     wait_q    <= 1'b1;
                     state     <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (wait_q) begin
                  wait_q <= 1'b0;
               end else begin
                  out_data  <= data_out;
                  out_valid <= 1'b1;
                  cnt       <= (cnt != 8'h00) ? cnt - 8'h01 : cnt;
`ifdef PKT_TX_FRAMER_CRC16_EN
                  crc_q     <= crc_step(crc_q, data_out);
                  out_last  <= 1'b0;
`else
                  out_last  <= (cnt == 8'h01);
`endif
                  state     <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (out_ready) begin
                  if (cnt == 8'h00) begin
`ifdef PKT_TX_FRAMER_CRC16_EN
                     out_data  <= crc_q[15:8];
                     out_last  <= 1'b0;
                     state     <= CRC_HI;
`else
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     state     <= FINISH;
`endif
                  end else begin
                     // Next read only after the current byte has left.
                     out_valid <= 1'b0;
                     rd_en     <= 1'b1;
                     wait_q    <= 1'b1;
                     state     <= FETCH;
                  end
               end
            end
`ifdef PKT_TX_FRAMER_CRC16_EN
            CRC_HI: begin
               if (out_ready) begin
                  out_data <= crc_q[7:0];
                  out_last <= 1'b1;
                  state    <= CRC_LO;
               end
            end
            CRC_LO: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  done      <= 1'b1;
                  state     <= FINISH;
               end
            end
`endif
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Self-checking bench for pkt_tx_framer: FIFO model, frame-level expected-byte
// queue built from the framing rules, and a per-cycle stream monitor.
`timescale 1ns/1ps
module tb_pkt_tx_framer;

   localparam int         PRE_LEN = 2;
   localparam logic [7:0] SYNC    = 8'hD3;
   localparam int         MAXL    = 64;
`ifdef PKT_TX_FRAMER_CRC16_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pkt_ready = 1'b0;
   logic [7:0] length_out = 8'h00;
   logic       length_rd_en;
   logic [7:0] data_out = 8'h00;
   logic       rd_en;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_last;
   logic       busy;
   logic       done;
   logic       len_err;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] fifo_q[$];
   logic [7:0] cur_len = 8'h00;
   int  exp_len = 0;
   int  rd_cnt = 0;
   int  pay_xfer = 0;
   int  xfer_idx = 0;
   int  done_cnt = 0;
   int  err_cnt = 0;
   int  valid_cnt = 0;
   bit  rand_rdy = 1'b0;

   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_last = 1'b0;
   logic       prev_rd = 1'b0;
   logic       prev_lrd = 1'b0;
   logic       prev_done = 1'b0;

   pkt_tx_framer #(.PREAMBLE_LEN(PRE_LEN), .SYNC_BYTE(SYNC), .MAX_LEN(MAXL)) dut (
      .clk(clk), .reset_n(reset_n), .pkt_ready(pkt_ready),
      .length_out(length_out), .length_rd_en(length_rd_en),
      .data_out(data_out), .rd_en(rd_en),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done), .len_err(len_err));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Bit-serial CRC-16/CCITT-FALSE reference.
   function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
      logic [15:0] c;
      logic fb;
      c = 16'hFFFF;
      foreach (b[i]) begin
         for (int k = 7; k >= 0; k--) begin
            fb = c[15] ^ b[i][k];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   // Packet FIFO: registered length and data, one cycle after their strobes.
   always @(posedge clk) begin
      logic [7:0] b;
      if (length_rd_en) length_out <= cur_len;
      if (rd_en && fifo_q.size() > 0) begin
         b = fifo_q.pop_front();
         data_out <= b;
      end
   end

   // Stream monitor: decides out_ready for the coming edge, then checks what that edge will do.
   always @(negedge clk) begin
      logic [7:0] e;
      out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!reset_n) begin
         prev_stall = 1'b0; prev_rd = 1'b0; prev_lrd = 1'b0; prev_done = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
         end
         if (rd_en) begin
            chk("rd_single_cycle", prev_rd, 1'b0);
            chk("rd_outstanding", rd_cnt, pay_xfer);
            chk("rd_while_valid", out_valid, 1'b0);
            rd_cnt++;
         end
         if (length_rd_en) chk("length_rd_single_cycle", prev_lrd, 1'b0);
         if (out_valid || rd_en || done) chk("busy_active", busy, 1'b1);
         if (out_valid) valid_cnt++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL extra_byte: got %0h, required no transfer", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("byte", out_data, e);
               chk("last", out_last, exp_q.size() == 0);
               got_q.push_back(out_data);
               if (xfer_idx >= PRE_LEN + 2 && xfer_idx < PRE_LEN + 2 + exp_len) pay_xfer++;
               xfer_idx++;
            end
         end
         if (done) begin
            chk("done_single_cycle", prev_done, 1'b0);
            chk("done_after_last", exp_q.size(), 0);
            chk("done_rd_count", rd_cnt, exp_len);
            done_cnt++;
         end
         if (len_err) err_cnt++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         prev_rd    = rd_en;
         prev_lrd   = length_rd_en;
         prev_done  = done;
      end
   end

   task automatic start_frame(input int len, input logic [7:0] pay[$]);
      int n;
      exp_q.delete(); got_q.delete();
      rd_cnt = 0; pay_xfer = 0; xfer_idx = 0; exp_len = len;
      cur_len = 8'(len);
      fifo_q = pay;
      if (len <= MAXL) begin
         logic [15:0] c;
         for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(8'hAA);
         exp_q.push_back(SYNC);
         exp_q.push_back(8'(len));
         foreach (pay[i]) exp_q.push_back(pay[i]);
         if (CRC_ON) begin
            c = model_crc(pay);
            exp_q.push_back(c[15:8]);
            exp_q.push_back(c[7:0]);
         end
      end
      @(posedge clk); #1;
      pkt_ready = 1'b1;
      n = 0;
      while (!length_rd_en && n < 10) begin @(posedge clk); #1; n++; end
      chk("length_rd_en_seen", length_rd_en, 1'b1);
      pkt_ready = 1'b0;
   endtask

   task automatic run_frame(input int len, input logic [7:0] pay[$]);
      int d0, e0, v0, n;
      d0 = done_cnt; e0 = err_cnt; v0 = valid_cnt;
      start_frame(len, pay);
      if (len > MAXL) begin
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk("len_err_pulse", len_err, 1'b1);
         chk("len_err_busy_low", busy, 1'b0);
         @(posedge clk); #1;
         chk("len_err_single_cycle", len_err, 1'b0);
         repeat (3) @(posedge clk);
         #1;
         chk("err_no_valid", valid_cnt - v0, 0);
         chk("err_no_rd", rd_cnt, 0);
         chk("err_no_done", done_cnt - d0, 0);
         chk("err_count", err_cnt - e0, 1);
      end else begin
         n = 0;
         while (done_cnt == d0 && n < 3000) begin @(posedge clk); #1; n++; end
         chk("frame_done", done_cnt - d0, 1);
         chk("idle_busy_low", busy, 1'b0);
         chk("frame_rd_count", rd_cnt, len);
         chk("frame_bytes_left", exp_q.size(), 0);
         chk("frame_no_len_err", err_cnt - e0, 0);
      end
   endtask

   task automatic cmp_got(input string name, input logic [7:0] lit[$], input int total);
      chk({name, "_size"}, got_q.size(), total);
      foreach (lit[i]) begin
         if (i < got_q.size()) chk({name, "_byte"}, got_q[i], lit[i]);
      end
   endtask

   initial begin
      logic [7:0] pay[$];
      logic [7:0] lit[$];
      int len, n;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_rd_en", rd_en, 1'b0);
      chk("rst_length_rd_en", length_rd_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_len_err", len_err, 1'b0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Pin the CRC model against the published check value.
      pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      chk("model_crc_check_value", model_crc(pay), 16'h29B1);

      // Basic 3-byte frame, always ready.
      rand_rdy = 1'b0;
      pay = '{8'h01, 8'h02, 8'h03};
      run_frame(3, pay);
      lit = '{8'hAA, 8'hAA, 8'hD3, 8'h03, 8'h01, 8'h02, 8'h03};
      cmp_got("len3", lit, CRC_ON ? 9 : 7);

`ifdef PKT_TX_FRAMER_CRC16_EN
      pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      run_frame(9, pay);
      lit = '{8'hAA, 8'hAA, 8'hD3, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
              8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
      cmp_got("crc9", lit, 15);
`endif

      // Back-pressure on the same 3-byte frame.
      rand_rdy = 1'b1;
      pay = '{8'h01, 8'h02, 8'h03};
      run_frame(3, pay);
      lit = '{8'hAA, 8'hAA, 8'hD3, 8'h03, 8'h01, 8'h02, 8'h03};
      cmp_got("len3_stall", lit, CRC_ON ? 9 : 7);
      rand_rdy = 1'b0;

      // Empty payload.
      pay.delete();
      run_frame(0, pay);
      if (CRC_ON) lit = '{8'hAA, 8'hAA, 8'hD3, 8'h00, 8'hFF, 8'hFF};
      else        lit = '{8'hAA, 8'hAA, 8'hD3, 8'h00};
      cmp_got("len0", lit, CRC_ON ? 6 : 4);

      // Oversize length.
      pay.delete();
      run_frame(200, pay);

      // Largest legal and first illegal length.
      pay.delete();
      for (int i = 0; i < MAXL; i++) pay.push_back(8'($urandom_range(0, 255)));
      run_frame(MAXL, pay);
      pay.delete();
      run_frame(MAXL + 1, pay);

      // Reset after the second payload byte.
      pay = '{8'h11, 8'h22, 8'h33};
      start_frame(3, pay);
      n = 0;
      while (pay_xfer < 2 && n < 100) begin @(posedge clk); #1; n++; end
      chk("mid_frame_progress", pay_xfer, 2);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_out_data", out_data, 8'h00);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_out_last", out_last, 1'b0);
      chk("mid_rst_rd_en", rd_en, 1'b0);
      chk("mid_rst_length_rd_en", length_rd_en, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_len_err", len_err, 1'b0);
      reset_n = 1'b1;
      exp_q.delete(); fifo_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_no_rd", rd_en, 1'b0);
         chk("post_rst_no_valid", out_valid, 1'b0);
      end
      pay = '{8'h01, 8'h02, 8'h03};
      run_frame(3, pay);
      lit = '{8'hAA, 8'hAA, 8'hD3, 8'h03, 8'h01, 8'h02, 8'h03};
      cmp_got("after_reset", lit, CRC_ON ? 9 : 7);

      // Randomized frames.
      for (int f = 0; f < 14; f++) begin
         rand_rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) len = $urandom_range(MAXL + 1, 255);
         else                           len = $urandom_range(0, MAXL);
         pay.delete();
         if (len <= MAXL)
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
         run_frame(len, pay);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
